turbo_ctrl_fsm: RTL and testbench



---
 rtl/turbo_ctrl_pkg.sv | 36 +++
 rtl/turbo_ctrl_cnt.sv | 45 ++++
 rtl/turbo_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_turbo_ctrl_fsm.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_ctrl_pkg.sv
// Shared definitions for the turbo encoder control FSM: state encoding,
// default tail length, standard block lengths and the per-state control word.
package turbo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ENCODE = 2'd1,
      ST_TAIL   = 2'd2
   } state_e;

   localparam int TAIL_LEN_DEF = 4;

   localparam int LEN_1000 = 1000;
   localparam int LEN_6000 = 6000;
   localparam int LEN_6144 = 6144;

   typedef struct packed {
      logic enable;
      logic trellis;
      logic clr;
      logic busy;
   } ctrl_t;

   // Control levels held for the whole time the FSM sits in a state.
   function automatic ctrl_t ctrl_of(input state_e s);
      ctrl_t c;
      c = '{enable: 1'b0, trellis: 1'b0, clr: 1'b1, busy: 1'b0};
      case (s)
         ST_ENCODE: c = '{enable: 1'b1, trellis: 1'b0, clr: 1'b0, busy: 1'b1};
         ST_TAIL:   c = '{enable: 1'b0, trellis: 1'b1, clr: 1'b1, busy: 1'b1};
         default:   c = '{enable: 1'b0, trellis: 1'b0, clr: 1'b1, busy: 1'b0};
      endcase
      return c;
   endfunction

endpackage

// File: rtl/turbo_ctrl_cnt.sv
// Cycle counter for the control FSM: clear/increment, with terminal-count and
// one-before-terminal flags against either the block length or the tail length.
module turbo_ctrl_cnt
   import turbo_ctrl_pkg::*;
#(
   parameter int CNT_W    = 13,
   parameter int TAIL_LEN = TAIL_LEN_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr_i,
   input  logic             inc_i,
   input  logic             sel_tail_i,
   input  logic [CNT_W-1:0] k_i,
   output logic             tc_o,
   output logic             pre_tc_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] limit;

   always_comb begin
      limit = sel_tail_i ? CNT_W'(TAIL_LEN) : k_i;
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o     = (cnt_q == limit - CNT_W'(1));
   assign pre_tc_o = (limit > CNT_W'(1)) && (cnt_q == limit - CNT_W'(2));

endmodule

// File: rtl/turbo_ctrl_fsm.sv
// Turbo encoder control FSM: IDLE -> ENCODE (K cycles) -> TAIL (TAIL_LEN cycles),
// with runtime block length, chaining, abort, done/busy, length error and block count.
module turbo_ctrl_fsm
   import turbo_ctrl_pkg::*;
#(
   parameter int CNT_W     = $clog2(LEN_6144 + 1),
   parameter int TAIL_LEN  = TAIL_LEN_DEF,
   parameter int CHAIN_EN  = 1,
   parameter int BLK_CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 data_valid,
   input  logic [CNT_W-1:0]     blk_len,
   input  logic                 abort,
   output logic                 enable,
   output logic                 trellis_enable,
   output logic                 switch,
   output logic                 clr,
   output logic [1:0]           current_state,
   output logic                 busy,
   output logic                 done,
   output logic                 len_err,
   output logic [BLK_CNT_W-1:0] blk_cnt
);

   state_e                 state_q;
   ctrl_t                  ctrl_q;
   logic                   done_q;
   logic                   len_err_q;
   logic [BLK_CNT_W-1:0]   blk_cnt_q;
   logic [CNT_W-1:0]       k_q;

   logic tc;
   logic pre_tc;
   logic cnt_clr;
   logic active;

   assign active  = (state_q == ST_ENCODE) || (state_q == ST_TAIL);
   assign cnt_clr = !active || abort || tc;

   turbo_ctrl_cnt #(
      .CNT_W    (CNT_W),
      .TAIL_LEN (TAIL_LEN)
   ) u_cnt (
      .clk        (clk),
      .reset_n    (reset_n),
      .clr_i      (cnt_clr),
      .inc_i      (active),
      .sel_tail_i (state_q == ST_TAIL),
      .k_i        (k_q),
      .tc_o       (tc),
      .pre_tc_o   (pre_tc)
   );

   // done and blk_cnt are set one edge early so they coincide with the last TAIL cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= ctrl_of(ST_IDLE);
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         blk_cnt_q <= '0;
         k_q       <= '0;
      end else begin
         done_q    <= 1'b0;
         len_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (data_valid) begin
                  if (blk_len != '0) begin
                     k_q     <= blk_len;
                     state_q <= ST_ENCODE;
                     ctrl_q  <= ctrl_of(ST_ENCODE);
                  end else begin
                     len_err_q <= 1'b1;
                  end
               end
            end
            ST_ENCODE: begin
               if (abort) begin
                  state_q <= ST_IDLE;
                  ctrl_q  <= ctrl_of(ST_IDLE);
               end else if (tc) begin
                  state_q <= ST_TAIL;
                  ctrl_q  <= ctrl_of(ST_TAIL);
                  if (TAIL_LEN == 1) begin
                     done_q    <= 1'b1;
                     blk_cnt_q <= blk_cnt_q + 1'b1;
                  end
               end
            end
            ST_TAIL: begin
               if (abort) begin
                  // A block whose done has already shown stays counted; abort only cancels a chained start.
                  state_q <= ST_IDLE;
                  ctrl_q  <= ctrl_of(ST_IDLE);
               end else if (tc) begin
                  if ((CHAIN_EN != 0) && data_valid && (blk_len != '0)) begin
                     k_q     <= blk_len;
                     state_q <= ST_ENCODE;
                     ctrl_q  <= ctrl_of(ST_ENCODE);
                  end else begin
                     state_q   <= ST_IDLE;
                     ctrl_q    <= ctrl_of(ST_IDLE);
                     len_err_q <= (CHAIN_EN != 0) && data_valid;
                  end
               end else if (pre_tc) begin
                  done_q    <= 1'b1;
                  blk_cnt_q <= blk_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ctrl_q  <= ctrl_of(ST_IDLE);
            end
         endcase
      end
   end

   assign enable         = ctrl_q.enable;
   assign trellis_enable = ctrl_q.trellis;
   assign switch         = ctrl_q.trellis;
   assign clr            = ctrl_q.clr;
   assign busy           = ctrl_q.busy;
   assign current_state  = state_q;
   assign done           = done_q;
   assign len_err        = len_err_q;
   assign blk_cnt        = blk_cnt_q;

endmodule

// File: tb/tb_turbo_ctrl_fsm.sv
// Directed bench for turbo_ctrl_fsm: default, no-chain and small-counter/TAIL_LEN=1
// instances share stimulus; each test segment checks one instance.
module tb_turbo_ctrl_fsm;
   import turbo_ctrl_pkg::*;

   localparam int CNT_W = 13;

   logic             clk;
   logic             reset_n;
   logic             data_valid;
   logic [CNT_W-1:0] blk_len;
   logic             abort;

   logic        en0, tr0, sw0, clr0, busy0, done0, le0;
   logic [1:0]  st0;
   logic [15:0] bc0;
   logic        en1, tr1, sw1, clr1, busy1, done1, le1;
   logic [1:0]  st1;
   logic [15:0] bc1;
   logic        en2, tr2, sw2, clr2, busy2, done2, le2;
   logic [1:0]  st2;
   logic [1:0]  bc2;

   int          sel;
   logic [8:0]  obs_vec;
   logic [15:0] obs_bc;

   int total = 0;
   int bad   = 0;

   // {state, enable, trellis, switch, clr, busy, done, len_err}
   localparam logic [8:0] V_IDLE = 9'b00_0001000;
   localparam logic [8:0] V_LERR = 9'b00_0001001;
   localparam logic [8:0] V_ENC  = 9'b01_1000100;
   localparam logic [8:0] V_TAIL = 9'b10_0111100;
   localparam logic [8:0] V_LAST = 9'b10_0111110;

   turbo_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .blk_len(blk_len), .abort(abort),
      .enable(en0), .trellis_enable(tr0), .switch(sw0), .clr(clr0), .current_state(st0),
      .busy(busy0), .done(done0), .len_err(le0), .blk_cnt(bc0)
   );

   turbo_ctrl_fsm #(.CNT_W(CNT_W), .CHAIN_EN(0)) dut_nc (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .blk_len(blk_len), .abort(abort),
      .enable(en1), .trellis_enable(tr1), .switch(sw1), .clr(clr1), .current_state(st1),
      .busy(busy1), .done(done1), .len_err(le1), .blk_cnt(bc1)
   );

   turbo_ctrl_fsm #(.CNT_W(CNT_W), .TAIL_LEN(1), .BLK_CNT_W(2)) dut_w (
      .clk(clk), .reset_n(reset_n), .data_valid(data_valid), .blk_len(blk_len), .abort(abort),
      .enable(en2), .trellis_enable(tr2), .switch(sw2), .clr(clr2), .current_state(st2),
      .busy(busy2), .done(done2), .len_err(le2), .blk_cnt(bc2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      obs_vec = '0;
      obs_bc  = '0;
      case (sel)
         0: begin
            obs_vec = {st0, en0, tr0, sw0, clr0, busy0, done0, le0};
            obs_bc  = bc0;
         end
         1: begin
            obs_vec = {st1, en1, tr1, sw1, clr1, busy1, done1, le1};
            obs_bc  = bc1;
         end
         default: begin
            obs_vec = {st2, en2, tr2, sw2, clr2, busy2, done2, le2};
            obs_bc  = {14'd0, bc2};
         end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n    = 1'b0;
      data_valid = 1'b0;
      abort      = 1'b0;
      blk_len    = '0;
      tick();
      reset_n = 1'b1;
   endtask

   // Starts on the first enable cycle, ends (without ticking) on the last TAIL cycle.
   task automatic expect_block(input string tag, input int k, input int tl);
      for (int i = 0; i < k + tl; i++) begin
         if (i < k)                check($sformatf("%s enc c%0d", tag, i), obs_vec, V_ENC);
         else if (i < k + tl - 1)  check($sformatf("%s tail c%0d", tag, i), obs_vec, V_TAIL);
         else                      check($sformatf("%s last c%0d", tag, i), obs_vec, V_LAST);
         if (i < k + tl - 1) tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] wrap_exp [5];
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3; wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      sel        = 0;
      reset_n    = 1'b0;
      data_valid = 1'b0;
      abort      = 1'b0;
      blk_len    = '0;
      tick();
      tick();
      check("reset vec", obs_vec, V_IDLE);
      check("reset blk_cnt", obs_bc, 16'd0);

      // Basic block, K=40
      reset_n    = 1'b1;
      data_valid = 1'b1;
      blk_len    = 13'd40;
      tick();
      data_valid = 1'b0;
      expect_block("basic", 40, 4);
      check("basic blk_cnt at done", obs_bc, 16'd1);
      tick();
      check("basic idle", obs_vec, V_IDLE);
      check("basic blk_cnt", obs_bc, 16'd1);

      // Chaining, CHAIN_EN=1; data_valid held through ENCODE must be ignored
      do_reset();
      data_valid = 1'b1;
      blk_len    = 13'd8;
      tick();
      blk_len = 13'd5;
      expect_block("chain1", 8, 4);
      blk_len = 13'd16;
      tick();
      data_valid = 1'b0;
      expect_block("chain2", 16, 4);
      check("chain blk_cnt", obs_bc, 16'd2);
      tick();
      check("chain idle", obs_vec, V_IDLE);

      // Same stimulus, CHAIN_EN=0
      sel = 1;
      do_reset();
      data_valid = 1'b1;
      blk_len    = 13'd8;
      tick();
      blk_len = 13'd5;
      expect_block("nochain", 8, 4);
      blk_len = 13'd16;
      tick();
      data_valid = 1'b0;
      check("nochain idle gap", obs_vec, V_IDLE);
      tick();
      check("nochain start ignored", obs_vec, V_IDLE);
      check("nochain blk_cnt", obs_bc, 16'd1);

      // Length error in IDLE and on a chained start
      sel = 0;
      do_reset();
      data_valid = 1'b1;
      blk_len    = '0;
      tick();
      data_valid = 1'b0;
      check("len_err idle pulse", obs_vec, V_LERR);
      tick();
      check("len_err idle clears", obs_vec, V_IDLE);
      data_valid = 1'b1;
      blk_len    = 13'd2;
      tick();
      data_valid = 1'b0;
      expect_block("lerr blk", 2, 4);
      data_valid = 1'b1;
      blk_len    = '0;
      tick();
      data_valid = 1'b0;
      check("len_err chained pulse", obs_vec, V_LERR);
      tick();
      check("len_err chained clears", obs_vec, V_IDLE);

      // Abort at counter 50 of K=100, then fresh start with abort high in IDLE
      do_reset();
      data_valid = 1'b1;
      blk_len    = 13'd100;
      tick();
      data_valid = 1'b0;
      for (int i = 0; i < 50; i++) begin
         check($sformatf("abort pre c%0d", i), obs_vec, V_ENC);
         tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort idle", obs_vec, V_IDLE);
      check("abort blk_cnt", obs_bc, 16'd0);
      data_valid = 1'b1;
      abort      = 1'b1;
      tick();
      data_valid = 1'b0;
      abort      = 1'b0;
      expect_block("post abort", 100, 4);
      check("post abort blk_cnt", obs_bc, 16'd1);
      data_valid = 1'b1;
      blk_len    = 13'd5;
      abort      = 1'b1;
      tick();
      data_valid = 1'b0;
      abort      = 1'b0;
      check("abort beats chain", obs_vec, V_IDLE);
      check("abort beats chain cnt", obs_bc, 16'd1);

      // Mid-block reset in TAIL cycle 2 of a K=6144 block
      do_reset();
      data_valid = 1'b1;
      blk_len    = 13'd2;
      tick();
      data_valid = 1'b0;
      expect_block("pre big", 2, 4);
      data_valid = 1'b1;
      blk_len    = CNT_W'(LEN_6144);
      tick();
      data_valid = 1'b0;
      repeat (LEN_6144) tick();
      check("big tail0", obs_vec, V_TAIL);
      tick();
      tick();
      check("big tail2", obs_vec, V_TAIL);
      check("big blk_cnt pre", obs_bc, 16'd1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("midreset vec", obs_vec, V_IDLE);
      check("midreset blk_cnt", obs_bc, 16'd0);

      // Counter wrap with BLK_CNT_W=2 and one-cycle tail
      sel = 2;
      do_reset();
      for (int b = 0; b < 5; b++) begin
         data_valid = 1'b1;
         blk_len    = 13'd4;
         tick();
         data_valid = 1'b0;
         expect_block($sformatf("wrap b%0d", b), 4, 1);
         check($sformatf("wrap blk_cnt b%0d", b), obs_bc, {14'd0, wrap_exp[b]});
         tick();
         check($sformatf("wrap idle b%0d", b), obs_vec, V_IDLE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
